// File: rtl/mm_stream_feeder.sv
// Transmit-side companion of the streaming matrix multiplier: streams matrices A then B
// onto the multiplier byte stream and captures its result stream into a readable buffer.
module mm_stream_feeder #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cfg_we_i,
    input  logic        cfg_sel_i,
    input  logic [3:0]  cfg_addr_i,
    input  logic [7:0]  cfg_data_i,
    input  logic [2:0]  a_rows_i,
    input  logic [2:0]  a_cols_i,
    input  logic [2:0]  b_rows_i,
    input  logic [2:0]  b_cols_i,
    input  logic        start_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_col_end_o,
    output logic        tx_row_end_o,
    input  logic        mm_busy_i,
    input  logic        mm_valid_i,
    input  logic        mm_is_legal_i,
    input  logic [1:0]  mm_ep_i,
    input  logic [11:0] mm_data_i,
    input  logic [3:0]  rd_addr_i,
    output logic [11:0] rd_data_o,
    output logic [4:0]  res_count_o,
    output logic [3:0]  status_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_RDY = 3'd1;
    localparam logic [2:0] S_SEND_A   = 3'd2;
    localparam logic [2:0] S_GAP_A    = 3'd3;
    localparam logic [2:0] S_SEND_B   = 3'd4;
    localparam logic [2:0] S_GAP_B    = 3'd5;
    localparam logic [2:0] S_WAIT_RES = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    logic [2:0]  state_q, state_d;
    logic [2:0]  ar_q, ar_d, ac_q, ac_d, br_q, br_d, bc_q, bc_d;
    logic [2:0]  r_q, r_d, c_q, c_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] idle_q, idle_d;
    logic [4:0]  res_count_q, res_count_d;
    logic [3:0]  status_q, status_d;
    logic        prev_valid_q;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_col_q, tx_col_d;
    logic        tx_row_q, tx_row_d;
    logic        busy_q;
    logic        done_q;

    logic [7:0]  a_mem_q   [16];
    logic [7:0]  b_mem_q   [16];
    logic [11:0] res_mem_q [16];

    logic        res_we_s;
    logic        capture_s;
    logic        last_col_s;
    logic        last_row_s;
    logic [2:0]  cur_rows_s;
    logic [2:0]  cur_cols_s;
    logic [4:0]  exp_count_s;

    function automatic logic dim_bad(input logic [2:0] d);
        return (d == 3'd0) || (d > 3'd4);
    endfunction

    assign capture_s   = mm_valid_i && !prev_valid_q;
    assign cur_rows_s  = (state_q == S_SEND_B) ? br_q : ar_q;
    assign cur_cols_s  = (state_q == S_SEND_B) ? bc_q : ac_q;
    assign last_col_s  = (c_q == (cur_cols_s - 3'd1));
    assign last_row_s  = (r_q == (cur_rows_s - 3'd1));
    assign exp_count_s = {2'b00, ar_q} * {2'b00, bc_q};

    // Sequencer next-state: dimension check, stream walk and result capture.
    always_comb begin
        state_d     = state_q;
        ar_d        = ar_q;
        ac_d        = ac_q;
        br_d        = br_q;
        bc_d        = bc_q;
        r_d         = r_q;
        c_d         = c_q;
        idx_d       = idx_q;
        idle_d      = idle_q;
        res_count_d = res_count_q;
        status_d    = status_q;
        res_we_s    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    ar_d = a_rows_i;
                    ac_d = a_cols_i;
                    br_d = b_rows_i;
                    bc_d = b_cols_i;
                    if (dim_bad(a_rows_i) || dim_bad(a_cols_i) ||
                        dim_bad(b_rows_i) || dim_bad(b_cols_i)) begin
                        status_d = 4'b1000;
                        state_d  = S_DONE;
                    end else begin
                        res_count_d = 5'd0;
                        status_d    = 4'b0000;
                        state_d     = S_WAIT_RDY;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_RDY: begin
                if (!mm_busy_i) begin
                    state_d = S_SEND_A;
                    r_d     = 3'd0;
                    c_d     = 3'd0;
                    idx_d   = 4'd0;
                end else begin
                    state_d = S_WAIT_RDY;
                end
            end
            S_SEND_A, S_SEND_B: begin
                idx_d = idx_q + 4'd1;
                if (last_col_s && last_row_s) begin
                    state_d = (state_q == S_SEND_A) ? S_GAP_A : S_GAP_B;
                    r_d     = 3'd0;
                    c_d     = 3'd0;
                    idx_d   = 4'd0;
                end else if (last_col_s) begin
                    r_d = r_q + 3'd1;
                    c_d = 3'd0;
                end else begin
                    c_d = c_q + 3'd1;
                end
            end
            S_GAP_A: begin
                state_d = S_SEND_B;
            end
            S_GAP_B: begin
                state_d = S_WAIT_RES;
                idle_d  = 16'd0;
            end
            S_WAIT_RES: begin
                if (capture_s) begin
                    idle_d = 16'd0;
                    if (mm_is_legal_i) begin
                        res_we_s    = 1'b1;
                        res_count_d = res_count_q + 5'd1;
                        if (res_count_d == exp_count_s) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_WAIT_RES;
                        end
                    end else begin
                        // ep = 0 on an illegal result would be indistinguishable from "no error"
                        status_d[1:0] = (mm_ep_i == 2'b00) ? 2'b11 : mm_ep_i;
                        state_d       = S_DONE;
                    end
                end else begin
                    idle_d = idle_q + 16'd1;
                    if (idle_d == TIMEOUT_C) begin
                        status_d[2] = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_WAIT_RES;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stream byte and markers for the next cycle; gaps repeat the last element sent.
    always_comb begin
        tx_data_d = 8'h00;
        tx_col_d  = 1'b0;
        tx_row_d  = 1'b0;
        case (state_d)
            S_SEND_A: begin
                tx_data_d = a_mem_q[idx_d];
                tx_col_d  = (c_d == (ac_q - 3'd1));
                tx_row_d  = tx_col_d && (r_d == (ar_q - 3'd1));
            end
            S_SEND_B: begin
                tx_data_d = b_mem_q[idx_d];
                tx_col_d  = (c_d == (bc_q - 3'd1));
                tx_row_d  = tx_col_d && (r_d == (br_q - 3'd1));
            end
            S_GAP_A, S_GAP_B: begin
                tx_data_d = tx_data_q;
            end
            default: begin
                tx_data_d = 8'h00;
            end
        endcase
    end

    // Control state, counters and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            ar_q         <= 3'd0;
            ac_q         <= 3'd0;
            br_q         <= 3'd0;
            bc_q         <= 3'd0;
            r_q          <= 3'd0;
            c_q          <= 3'd0;
            idx_q        <= 4'd0;
            idle_q       <= 16'd0;
            res_count_q  <= 5'd0;
            status_q     <= 4'd0;
            prev_valid_q <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_col_q     <= 1'b0;
            tx_row_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ar_q         <= ar_d;
            ac_q         <= ac_d;
            br_q         <= br_d;
            bc_q         <= bc_d;
            r_q          <= r_d;
            c_q          <= c_d;
            idx_q        <= idx_d;
            idle_q       <= idle_d;
            res_count_q  <= res_count_d;
            status_q     <= status_d;
            prev_valid_q <= mm_valid_i;
            tx_data_q    <= tx_data_d;
            tx_col_q     <= tx_col_d;
            tx_row_q     <= tx_row_d;
            busy_q       <= (state_d != S_IDLE);
            done_q       <= (state_q == S_DONE);
        end
    end

    // Matrix and result storage; contents are not reset.
    always_ff @(posedge clk_i) begin
        if (cfg_we_i && (state_q == S_IDLE)) begin
            if (cfg_sel_i) begin
                b_mem_q[cfg_addr_i] <= cfg_data_i;
            end else begin
                a_mem_q[cfg_addr_i] <= cfg_data_i;
            end
        end
        if (res_we_s) begin
            res_mem_q[res_count_q[3:0]] <= mm_data_i;
        end
    end

    assign tx_data_o    = tx_data_q;
    assign tx_col_end_o = tx_col_q;
    assign tx_row_end_o = tx_row_q;
    assign rd_data_o    = res_mem_q[rd_addr_i];
    assign res_count_o  = res_count_q;
    assign status_o     = status_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule
